mr_wb: RTL and testbench

MR_WB -- requirements
Module: mr_wb

---
 rtl/mr_wb.sv | 167 ++++++++++++++++
 tb/tb_mr_wb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mr_wb.sv
// rtl/mr_wb.sv - writeback stage: register file, in-order commit check, mispredict redirect and wrong-path flush
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 8
`endif

package mr_wb_pkg;
  typedef enum logic [1:0] {
    PAYLOAD_NONE    = 2'd0,
    PAYLOAD_JUMPDST = 2'd1,
    PAYLOAD_STADDR  = 2'd2
  } e_payload;
endpackage

module mr_wb
  import mr_wb_pkg::*;
#(
  parameter int RETIRE_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_write_i,
  input  logic [`INSTID_BITS-1:0] wb_instid_i,
  input  logic [`XLEN-1:0]        wb_data_i,
  input  logic [`REGSEL_BITS-1:0] wb_dst_reg_i,
  input  logic [`XLEN-1:0]        wb_payload_i,
  input  e_payload                wb_payload_kind_i,
  input  logic                    wb_is_jump_i,
  input  logic                    wb_jump_taken_i,
  input  logic                    wb_jump_predicted_i,
  input  logic [`REGSEL_BITS-1:0] rs1_sel_i,
  input  logic [`REGSEL_BITS-1:0] rs2_sel_i,
  output logic [`XLEN-1:0]        rs1_dat_o,
  output logic [`XLEN-1:0]        rs2_dat_o,
  output logic                    sb_clr_o,
  output logic [`REGSEL_BITS-1:0] sb_clr_reg_o,
  output logic                    redirect_o,
  output logic [`XLEN-1:0]        redirect_pc_o,
  output logic [`INSTID_BITS-1:0] redirect_instid_o,
  output logic                    flushing_o,
  output logic [RETIRE_W-1:0]     retired_o
);

  localparam int XW = `XLEN;
  localparam int RW = `REGSEL_BITS;
  localparam int IW = `INSTID_BITS;
  localparam int NREG = 1 << RW;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         exp_id_q, exp_id_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  redirect_q, redirect_d;
  logic [XW-1:0]         redirect_pc_q, redirect_pc_d;
  logic [IW-1:0]         redirect_instid_q, redirect_instid_d;
  logic [XW-1:0]         rf_q [NREG];

  logic id_match;
  logic commit;
  logic mispredict;

  // In FLUSH only the instruction fetch resumed at (exp_id) is on the right path.
  assign id_match   = (wb_instid_i == exp_id_q);
  assign commit     = rst && wb_write_i && ((state_q == S_RUN) || id_match);
  assign mispredict = commit && wb_is_jump_i && (wb_jump_taken_i != wb_jump_predicted_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mispredict) begin
      state_d = S_FLUSH;
    end else if (commit) begin
      state_d = S_RUN;
    end
  end

  // Dropped wrong-path results still clear their scoreboard bit.
  always_comb begin
    flushing_o   = (state_q == S_FLUSH);
    sb_clr_o     = rst && wb_write_i;
    sb_clr_reg_o = wb_dst_reg_i;
  end

  always_comb begin
    exp_id_d          = exp_id_q;
    retired_d         = retired_q;
    redirect_d        = mispredict;
    redirect_pc_d     = redirect_pc_q;
    redirect_instid_d = redirect_instid_q;
    if (commit) begin
      exp_id_d  = exp_id_q + IW'(1);
      retired_d = retired_q + RETIRE_W'(1);
    end
    if (mispredict) begin
      redirect_pc_d     = wb_jump_taken_i ? wb_payload_i : wb_data_i;
      redirect_instid_d = wb_instid_i + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_id_q          <= '0;
      retired_q         <= '0;
      redirect_q        <= 1'b0;
      redirect_pc_q     <= '0;
      redirect_instid_q <= '0;
    end else begin
      exp_id_q          <= exp_id_d;
      retired_q         <= retired_d;
      redirect_q        <= redirect_d;
      redirect_pc_q     <= redirect_pc_d;
      redirect_instid_q <= redirect_instid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit && (wb_dst_reg_i != '0)) begin
      rf_q[wb_dst_reg_i] <= wb_data_i;
    end
  end

  function automatic logic [XW-1:0] read_port(input logic [RW-1:0] sel);
    logic [XW-1:0] val;
    val = rf_q[sel];
    if (sel == '0) begin
      val = '0;
    end else if (commit && (wb_dst_reg_i == sel)) begin
      val = wb_data_i;
    end
    return val;
  endfunction

  assign rs1_dat_o         = read_port(rs1_sel_i);
  assign rs2_dat_o         = read_port(rs2_sel_i);
  assign redirect_o        = redirect_q;
  assign redirect_pc_o     = redirect_pc_q;
  assign redirect_instid_o = redirect_instid_q;
  assign retired_o         = retired_q;

  // Out-of-order results in RUN indicate an upstream bug; they are still committed.
  a_commit_order : assert property (@(posedge clk) disable iff (!rst)
    (wb_write_i && (state_q == S_RUN)) |-> id_match);

  a_taken_target : assert property (@(posedge clk) disable iff (!rst)
    (mispredict && wb_jump_taken_i) |-> (wb_payload_kind_i == PAYLOAD_JUMPDST));

endmodule

// File: tb/tb_mr_wb.sv
// tb/tb_mr_wb.sv - self-checking bench for mr_wb against a rule-level commit model
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 8
`endif

module tb_mr_wb;
  import mr_wb_pkg::*;

  localparam int XW   = `XLEN;
  localparam int RW   = `REGSEL_BITS;
  localparam int IW   = `INSTID_BITS;
  localparam int RETW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wb_write_i;
  logic [IW-1:0] wb_instid_i;
  logic [XW-1:0] wb_data_i;
  logic [RW-1:0] wb_dst_reg_i;
  logic [XW-1:0] wb_payload_i;
  e_payload      wb_payload_kind_i;
  logic          wb_is_jump_i, wb_jump_taken_i, wb_jump_predicted_i;
  logic [RW-1:0] rs1_sel_i, rs2_sel_i;
  logic [XW-1:0] rs1_dat_o, rs2_dat_o;
  logic          sb_clr_o;
  logic [RW-1:0] sb_clr_reg_o;
  logic          redirect_o;
  logic [XW-1:0] redirect_pc_o;
  logic [IW-1:0] redirect_instid_o;
  logic          flushing_o;
  logic [RETW-1:0] retired_o;

  mr_wb #(.RETIRE_W(RETW)) dut (
    .clk(clk), .rst(rst),
    .wb_write_i(wb_write_i), .wb_instid_i(wb_instid_i), .wb_data_i(wb_data_i),
    .wb_dst_reg_i(wb_dst_reg_i), .wb_payload_i(wb_payload_i),
    .wb_payload_kind_i(wb_payload_kind_i), .wb_is_jump_i(wb_is_jump_i),
    .wb_jump_taken_i(wb_jump_taken_i), .wb_jump_predicted_i(wb_jump_predicted_i),
    .rs1_sel_i(rs1_sel_i), .rs2_sel_i(rs2_sel_i),
    .rs1_dat_o(rs1_dat_o), .rs2_dat_o(rs2_dat_o),
    .sb_clr_o(sb_clr_o), .sb_clr_reg_o(sb_clr_reg_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .redirect_instid_o(redirect_instid_o), .flushing_o(flushing_o),
    .retired_o(retired_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state of the commit stream.
  logic [XW-1:0]   m_rf [32];
  logic [IW-1:0]   m_exp;
  logic [RETW-1:0] m_ret;
  bit              m_flush;
  bit              m_redir;
  logic [XW-1:0]   m_rpc;
  logic [IW-1:0]   m_rid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_exp = '0; m_ret = '0; m_flush = 0; m_redir = 0; m_rpc = '0; m_rid = '0;
  endtask

  function automatic logic [XW-1:0] exp_read(input logic [RW-1:0] sel, input bit c,
                                             input logic [RW-1:0] dst, input logic [XW-1:0] d);
    if (sel == 0) return '0;
    if (c && dst == sel) return d;
    return m_rf[sel];
  endfunction

  task automatic check_state();
    chk("retired", retired_o, m_ret);
    chk("flushing", flushing_o, m_flush);
    chk("redirect", redirect_o, m_redir);
    if (m_redir) begin
      chk("redirect_pc", redirect_pc_o, m_rpc);
      chk("redirect_instid", redirect_instid_o, m_rid);
    end
  endtask

  // One cycle of writeback; called just after a rising edge.
  task automatic wb(input bit w, input logic [IW-1:0] id, input logic [XW-1:0] data,
                    input logic [RW-1:0] dst, input bit isj, input bit tk, input bit pr,
                    input logic [XW-1:0] pay);
    bit c;
    wb_write_i = w; wb_instid_i = id; wb_data_i = data; wb_dst_reg_i = dst;
    wb_is_jump_i = isj; wb_jump_taken_i = tk; wb_jump_predicted_i = pr;
    wb_payload_i = pay;
    wb_payload_kind_i = isj ? PAYLOAD_JUMPDST : PAYLOAD_NONE;
    #1;
    c = w && (!m_flush || id == m_exp);
    chk("sb_clr", sb_clr_o, w);
    if (w) chk("sb_clr_reg", sb_clr_reg_o, dst);
    chk("rs1_dat", rs1_dat_o, exp_read(rs1_sel_i, c, dst, data));
    chk("rs2_dat", rs2_dat_o, exp_read(rs2_sel_i, c, dst, data));
    chk("flushing_pre", flushing_o, m_flush);
    @(posedge clk); #1;
    wb_write_i = 0;
    m_redir = 0;
    if (c) begin
      if (dst != 0) m_rf[dst] = data;
      m_ret++;
      m_exp++;
      m_flush = 0;
      if (isj && tk != pr) begin
        m_redir = 1;
        m_flush = 1;
        m_rpc = tk ? pay : data;
        m_rid = id + 1'b1;
      end
    end
    check_state();
  endtask

  task automatic idle();
    wb(0, IW'($urandom), XW'($urandom), RW'($urandom), 0, 0, 0, '0);
  endtask

  initial begin
    rst = 0; wb_write_i = 0; wb_instid_i = '0; wb_data_i = '0; wb_dst_reg_i = '0;
    wb_payload_i = '0; wb_payload_kind_i = PAYLOAD_NONE; wb_is_jump_i = 0;
    wb_jump_taken_i = 0; wb_jump_predicted_i = 0; rs1_sel_i = '0; rs2_sel_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_redirect_pc", redirect_pc_o, 0);
    chk("reset_redirect_instid", redirect_instid_o, 0);
    rst = 1;

    // Basic commits, x0 write ignored
    rs1_sel_i = 5; rs2_sel_i = 0;
    wb(1, 0, 32'h1234, 5, 0, 0, 0, '0);
    wb(1, 1, 32'hFFFF, 0, 0, 0, 0, '0);
    idle();
    chk("x5_read", rs1_dat_o, 32'h1234);
    chk("x0_read", rs2_dat_o, 0);
    chk("retired_two", retired_o, 2);

    // Same-cycle bypass
    rs1_sel_i = 5; rs2_sel_i = 7;
    wb(1, 2, 32'hA5A5A5A5, 7, 0, 0, 0, '0);

    // Taken mispredict
    wb(1, 3, 32'h44, 1, 1, 1, 0, 32'h80);
    chk("redir_pc_taken", redirect_pc_o, 32'h80);
    chk("redir_id_taken", redirect_instid_o, 4);
    idle();
    chk("redirect_one_cycle", redirect_o, 0);
    chk("flushing_held", flushing_o, 1);

    // Wrong-path results dropped, then the resume id commits
    rs1_sel_i = 3; rs2_sel_i = 9;
    wb(1, 7, 32'hDEAD, 3, 0, 0, 0, '0);
    wb(1, 8, 32'hBEEF, 9, 0, 0, 0, '0);
    wb(1, 4, 32'h55, 9, 0, 0, 0, '0);
    chk("flush_exit", flushing_o, 0);
    idle();
    chk("x9_after_flush", rs2_dat_o, 32'h55);
    chk("x3_not_written", rs1_dat_o, 0);

    // Not-taken mispredict, then a correctly predicted jump
    wb(1, 5, 32'h104, 1, 1, 0, 1, 32'h900);
    chk("redir_pc_nottaken", redirect_pc_o, 32'h104);
    wb(1, 6, 32'h11, 4, 0, 0, 0, '0);
    rs1_sel_i = 2;
    wb(1, 7, 32'h200, 2, 1, 1, 1, 32'h300);
    chk("no_redirect_correct", redirect_o, 0);
    idle();
    chk("link_written", rs1_dat_o, 32'h200);

    // Randomised commit stream
    for (int n = 0; n < 400; n++) begin
      bit w, isj, tk, pr;
      logic [IW-1:0] id;
      rs1_sel_i = RW'($urandom); rs2_sel_i = RW'($urandom);
      w = ($urandom_range(0, 3) != 0);
      isj = ($urandom_range(0, 3) == 0);
      tk = $urandom_range(0, 1);
      pr = ($urandom_range(0, 2) == 0) ? !tk : tk;
      if (m_flush && $urandom_range(0, 1) == 1) id = m_exp + IW'(1 + $urandom_range(0, 100));
      else if (w) id = m_exp;
      else id = IW'($urandom);
      wb(w, id, XW'($urandom), RW'($urandom), isj, tk, pr, XW'($urandom));
    end

    // Reset during FLUSH with a write present
    wb(1, m_exp, 32'h500, 1, 1, 1, 0, 32'h700);
    wb_write_i = 1; wb_instid_i = m_exp + IW'(3); wb_dst_reg_i = 9; wb_data_i = 32'h77;
    rst = 0;
    #1;
    chk("rst_retired", retired_o, 0);
    chk("rst_flushing", flushing_o, 0);
    chk("rst_redirect", redirect_o, 0);
    @(posedge clk); #1;
    wb_write_i = 0;
    rst = 1;
    model_reset();
    rs1_sel_i = 9; rs2_sel_i = 1;
    idle();
    chk("rst_x9_clear", rs1_dat_o, 0);
    chk("rst_x1_clear", rs2_dat_o, 0);
    wb(1, 0, 32'h42, 9, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
